// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller that registers ALU operands, captures result/flags and hands results to writeback.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR
  } alu_op_e;
  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } alu_flag_t;
endpackage

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int DEST_WIDTH = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  alu_op_e                   req_op,
  input  logic [DATA_BUS_WIDTH-1:0] req_a,
  input  logic [DATA_BUS_WIDTH-1:0] req_b,
  input  logic [DEST_WIDTH-1:0]     req_dest,
  input  logic                      req_wb,
  input  logic                      req_setflags,
  output alu_op_e                   alu_op,
  output logic [DATA_BUS_WIDTH-1:0] alu_reg1,
  output logic [DATA_BUS_WIDTH-1:0] alu_reg2,
  input  logic [DATA_BUS_WIDTH-1:0] alu_result,
  input  alu_flag_t                 alu_flag,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [DATA_BUS_WIDTH-1:0] wb_data,
  output logic [DEST_WIDTH-1:0]     wb_dest,
  output alu_flag_t                 flags_q,
  input  logic [$bits(alu_flag_t)-1:0] cond_mask,
  input  logic                      cond_invert,
  output logic                      cond_true,
  output logic                      busy,
  output logic [COUNT_WIDTH-1:0]    op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;
  state_e state, state_n;
  logic [DEST_WIDTH-1:0] dest;
  logic wb_en, sf_en;

  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign wb_valid = state == WB;
  assign cond_true = (|(flags_q & cond_mask)) ^ cond_invert;

  always_comb begin
    state_n = state;
    if (state == IDLE && req_valid) state_n = EXEC;
    else if (state == EXEC) state_n = wb_en ? WB : IDLE;
    else if (state == WB && wb_ready) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      alu_op <= alu_op_e'(0);
      alu_reg1 <= '0;
      alu_reg2 <= '0;
      dest <= '0;
      wb_en <= 1'b0;
      sf_en <= 1'b0;
      wb_data <= '0;
      wb_dest <= '0;
      flags_q <= '0;
      op_count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        alu_op <= req_op;
        alu_reg1 <= req_a;
        alu_reg2 <= req_b;
        dest <= req_dest;
        wb_en <= req_wb;
        sf_en <= req_setflags;
      end
      if (state == EXEC) begin
        if (sf_en) flags_q <= alu_flag;
        if (wb_en) begin
          wb_data <= alu_result;
          wb_dest <= dest;
        end
        op_count <= op_count + {{(COUNT_WIDTH-1){1'b0}}, ~&op_count};
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random checks of alu_sequencer against a behavioural ALU and sequencing model.
module tb_alu_sequencer;
  import alu_pkg::*;
  localparam int CW = 4;

  logic clk = 0, rst = 1;
  logic req_valid = 0, req_wb = 0, req_setflags = 0, wb_ready = 0, cond_invert = 0;
  alu_op_e req_op = ALU_ADD;
  logic [7:0] req_a = 0, req_b = 0;
  logic [2:0] req_dest = 0;
  logic [3:0] cond_mask = 0;
  logic req_ready, wb_valid, cond_true, busy;
  alu_op_e alu_op;
  logic [7:0] alu_reg1, alu_reg2, alu_result, wb_data;
  logic [2:0] wb_dest;
  alu_flag_t alu_flag, flags_q;
  logic [CW-1:0] op_count;
  logic [11:0] alu_out;

  int checks = 0, errors = 0;
  logic [3:0] exp_flags = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_BUS_WIDTH(8), .DEST_WIDTH(3), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_dest(req_dest),
    .req_wb(req_wb), .req_setflags(req_setflags), .alu_op(alu_op),
    .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_result(alu_result),
    .alu_flag(alu_flag), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_dest(wb_dest), .flags_q(flags_q),
    .cond_mask(cond_mask), .cond_invert(cond_invert), .cond_true(cond_true),
    .busy(busy), .op_count(op_count)
  );

  // Combinational ALU seen by the sequencer; returns {c,v,n,z,result}.
  function automatic logic [11:0] alu_ref(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    int s;
    logic c, v;
    logic [7:0] r;
    c = 0; v = 0; s = 0;
    case (op)
      ALU_ADD: begin s = int'(a) + int'(b); c = s > 255; v = (a[7] == b[7]) && (s[7] != a[7]); end
      ALU_SUB: begin s = int'(a) - int'(b); c = s < 0; v = (a[7] != b[7]) && (s[7] != a[7]); end
      ALU_AND: s = int'(a & b);
      ALU_OR:  s = int'(a | b);
      ALU_XOR: s = int'(a ^ b);
      ALU_NOT: s = int'(~a);
      ALU_SHL: begin s = int'(a) * 2; c = a[7]; end
      default: begin s = int'(a) / 2; c = a[0]; end
    endcase
    r = s[7:0];
    return {c, v, r[7], r == 0, r};
  endfunction

  assign alu_out = alu_ref(alu_op, alu_reg1, alu_reg2);
  assign alu_result = alu_out[7:0];
  assign alu_flag = alu_flag_t'(alu_out[11:8]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cond_check(input logic [3:0] m, input logic inv);
    cond_mask = m;
    cond_invert = inv;
    #1;
    chk("cond_true", cond_true, (|(exp_flags & m)) ^ inv);
  endtask

  task automatic do_op(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] d, input logic wb, input logic sf, input int stall);
    logic [11:0] ref_out;
    ref_out = alu_ref(op, a, b);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_dest = d; req_wb = wb; req_setflags = sf;
    wb_ready = stall == 0;
    tick;
    req_valid = $urandom_range(0, 1); req_a = 8'($urandom); req_b = 8'($urandom);
    req_op = alu_op_e'($urandom_range(0, 7)); req_dest = 3'($urandom);
    chk("exec_alu_op", alu_op, op);
    chk("exec_reg1", alu_reg1, a);
    chk("exec_reg2", alu_reg2, b);
    chk("exec_req_ready", req_ready, 0);
    chk("exec_busy", busy, 1);
    chk("exec_wb_valid", wb_valid, 0);
    tick;
    if (sf) exp_flags = ref_out[11:8];
    exp_count = exp_count < (1 << CW) - 1 ? exp_count + 1 : exp_count;
    chk("flags_q", flags_q, exp_flags);
    chk("op_count", op_count, exp_count);
    if (wb) begin
      chk("wb_valid", wb_valid, 1);
      chk("wb_data", wb_data, ref_out[7:0]);
      chk("wb_dest", wb_dest, d);
      chk("wb_req_ready", req_ready, 0);
      for (int i = 0; i < stall; i++) begin
        tick;
        chk("stall_wb_valid", wb_valid, 1);
        chk("stall_wb_data", wb_data, ref_out[7:0]);
        chk("stall_wb_dest", wb_dest, d);
        chk("stall_req_ready", req_ready, 0);
        chk("stall_busy", busy, 1);
      end
      wb_ready = 1;
      tick;
      chk("post_wb_valid", wb_valid, 0);
    end else chk("flagsonly_wb_valid", wb_valid, 0);
    req_valid = 0;
    wb_ready = 0;
    chk("post_req_ready", req_ready, 1);
    chk("post_alu_op_hold", alu_op, op);
    chk("post_reg1_hold", alu_reg1, a);
  endtask

  task automatic reset_checks(input string where);
    chk({where, "_wb_valid"}, wb_valid, 0);
    chk({where, "_alu_op"}, alu_op, 0);
    chk({where, "_reg1"}, alu_reg1, 0);
    chk({where, "_reg2"}, alu_reg2, 0);
    chk({where, "_wb_data"}, wb_data, 0);
    chk({where, "_wb_dest"}, wb_dest, 0);
    chk({where, "_flags"}, flags_q, 0);
    chk({where, "_count"}, op_count, 0);
    chk({where, "_busy"}, busy, 0);
  endtask

  initial begin
    #2;
    reset_checks("reset");
    tick;
    rst = 0;
    tick;
    chk("reset_req_ready", req_ready, 1);
    do_op(ALU_ADD, 8'h0F, 8'h01, 3'd3, 1, 1, 0);
    do_op(ALU_OR, 8'hA5, 8'h5A, 3'd6, 1, 1, 5);
    do_op(ALU_SUB, 8'h05, 8'h05, 3'd1, 0, 1, 0);
    chk("sub_zero_flag", flags_q.z, 1);
    cond_check(4'b0001, 0);
    cond_check(4'b0001, 1);
    do_op(ALU_ADD, 8'h80, 8'h80, 3'd2, 1, 0, 0);
    chk("noflag_zero_kept", flags_q.z, 1);
    cond_check(4'b0000, 1);
    cond_check(4'b0000, 0);
    // Abort in EXEC: reset must act without waiting for a clock edge.
    req_valid = 1; req_op = ALU_XOR; req_a = 8'h33; req_b = 8'h0F; req_wb = 1; req_setflags = 1;
    tick;
    req_valid = 0;
    rst = 1;
    #1;
    reset_checks("rst_exec");
    exp_flags = 0; exp_count = 0;
    tick;
    rst = 0;
    tick;
    chk("rst_exec_ready", req_ready, 1);
    req_valid = 1; req_op = ALU_SHL; req_a = 8'hC1; req_b = 8'h00; req_dest = 3'd5; req_wb = 1; req_setflags = 1;
    wb_ready = 0;
    tick;
    req_valid = 0;
    tick;
    chk("pre_rst_wb_valid", wb_valid, 1);
    rst = 1;
    #1;
    reset_checks("rst_wb");
    exp_flags = 0; exp_count = 0;
    tick;
    rst = 0;
    tick;
    for (int n = 0; n < 20; n++) begin
      do_op(alu_op_e'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      cond_check(4'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick;
    end
    chk("count_saturated", op_count, 4'hF);
    do_op(ALU_AND, 8'hF0, 8'h0F, 3'd7, 1, 1, 0);
    chk("count_stays_sat", op_count, 4'hF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
